core_select_arbiter: RTL

Round-robin scheduler that owns the `select_core` steering code for the shared four-core output multiplexer. It decides which core drives the shared bus, control-signal and flag outputs at any time. It grants the path to one requesting core, holds the grant for a bounded burst, and inserts a one-cycle idle turnaround between owners. It also tracks per-core end-of-program and raises a global completion flag once every core has finished.

---
 rtl/core_select_arbiter_pkg.sv | 9 +
 rtl/core_select_arbiter_if.sv | 14 +
 rtl/core_select_arbiter_rr_pick4.sv | 15 +
 rtl/core_select_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/core_select_arbiter_pkg.sv
// ccss_core_pkg: shared constants, FSM state type and steering-code helper for the core select arbiter
package ccss_core_pkg;
    localparam int NUM_CORES = 4;
    localparam logic [2:0] SEL_NONE = 3'd0;
    typedef enum logic [1:0] {IDLE, GRANT, TURN, DONE} state_t;
    function automatic logic [2:0] onehot_to_sel(input logic [NUM_CORES-1:0] oh);
        return oh[0] ? 3'd1 : oh[1] ? 3'd2 : oh[2] ? 3'd3 : oh[3] ? 3'd4 : SEL_NONE;
    endfunction
endpackage

// File: rtl/core_select_arbiter_if.sv
// core_select_arbiter_if: request/completion inputs and steering outputs of the shared output path
interface core_select_arbiter_if;
    import ccss_core_pkg::*;
    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] endp;
    logic [2:0]           select_core;
    logic [NUM_CORES-1:0] grant;
    logic                 busy;
    logic                 preempt;
    logic [NUM_CORES-1:0] done_mask;
    logic                 all_done;
    modport master (output req, endp, input select_core, grant, busy, preempt, done_mask, all_done);
    modport slave (input req, endp, output select_core, grant, busy, preempt, done_mask, all_done);
endinterface

// File: rtl/core_select_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker, first eligible core after the pointer wins
module rr_pick4 (
    input  logic [3:0] elig,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       valid
);
    // scan farthest-to-nearest so the nearest eligible core after last overwrites the rest
    always_comb begin
        idx = 2'd0;
        valid = |elig;
        for (int k = 4; k >= 1; k--)
            if (elig[last + 2'(k)]) idx = last + 2'(k);
    end
endmodule

// File: rtl/core_select_arbiter.sv
// core_select_arbiter: round-robin owner of the shared four-core output path with bounded bursts and completion tracking
module core_select_arbiter
    import ccss_core_pkg::*;
#(
    parameter int MAX_HOLD = 64
) (
    input logic clk,
    input logic rst,
    core_select_arbiter_if.slave bus
);
    state_t     state, state_n;
    logic [1:0] owner, owner_n, last, last_n, pick;
    logic [7:0] hold, hold_n;
    logic [3:0] done, done_n, elig, others, grant_n;
    logic       pick_v, rel, at_max, preempt_n;

    assign elig = bus.req & ~done;
    assign others = elig & ~(4'(1) << owner);
    assign rel = !bus.req[owner] || bus.endp[owner];
    assign at_max = hold == 8'(MAX_HOLD - 1);
    assign done_n = done | bus.endp;
    assign grant_n = (state_n == GRANT) ? 4'(1) << owner_n : 4'd0;
    assign bus.done_mask = done;
    assign bus.all_done = &done;

    rr_pick4 u_pick (.elig(elig), .last(last), .idx(pick), .valid(pick_v));

    // next-state: arbitration from IDLE/TURN, release/pre-emption/saturation in GRANT, absorbing DONE
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n = last;
        hold_n = hold;
        preempt_n = 1'b0;
        case (state)
            IDLE, TURN: begin
                if (&done) state_n = DONE;
                else if (pick_v) begin
                    state_n = GRANT;
                    owner_n = pick;
                    last_n = pick;
                    hold_n = 8'd0;
                end else state_n = IDLE;
            end
            GRANT: begin
                if (&done_n) state_n = DONE;
                else if (rel) state_n = TURN;
                else if (at_max && |others) begin
                    state_n = TURN;
                    preempt_n = 1'b1;
                end else if (!at_max) hold_n = hold + 8'd1;
            end
            default: state_n = DONE;
        endcase
    end

    // state, pointer, counters and registered steering outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 2'd0;
            last <= 2'd3;
            hold <= 8'd0;
            done <= 4'd0;
            bus.grant <= 4'd0;
            bus.select_core <= SEL_NONE;
            bus.busy <= 1'b0;
            bus.preempt <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last <= last_n;
            hold <= hold_n;
            done <= done_n;
            bus.grant <= grant_n;
            bus.select_core <= onehot_to_sel(grant_n);
            bus.busy <= state_n == GRANT;
            bus.preempt <= preempt_n;
        end
    end
endmodule
